// File: rtl/leftright_warn_filter.sv
// leftright_warn_filter
//   Takes operand-compare events, applies the LEFTRIGHT exemption and
//   suppression rules, and queues the surviving warnings for the reporter.
//   Per-module warning/drop counters and an end-of-module pulse once the
//   queue has fully drained.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high; ready never depends on valid, and out_* hold steady while
//   out_valid is high and out_ready is low.
//
//   Optional build macro LEFTRIGHT_DEDUP_EN: suppress a warning whose
//   {op,line} equals the most recently queued record.
module leftright_warn_filter #(
    parameter int LW    = 16,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic          in_same,
    input  logic          in_one,
    input  logic          in_sel,
    input  logic          in_ignore,
    input  logic [LW-1:0] in_line,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [LW-1:0] out_line,
    output logic [CW-1:0] warn_cnt,
    output logic [CW-1:0] drop_cnt,
    output logic          mod_done,
    output logic [1:0]    dbg_state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ASHL = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_MAX  = 4'd13;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    op_mem   [DEPTH];
    logic [LW-1:0] line_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, fill;
    logic          empty, full;
    logic          accept, is_warn, dup, warn_evt, push, pop, drop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill   = wr_ptr - rd_ptr;

    // Only RUN accepts events; derived from state alone to keep ready independent of valid.
    assign accept = in_valid && (state_q == S_RUN);

    // Exemption rules: MUL never warns, shifts-left of 1 by 1 and +/- in select context are idiomatic.
    always_comb begin
        is_warn = in_same && !in_ignore && (in_op <= OP_MAX) && (in_op != OP_MUL);
        if (((in_op == OP_SHL) || (in_op == OP_ASHL)) && in_one) begin
            is_warn = 1'b0;
        end
        if (((in_op == OP_ADD) || (in_op == OP_SUB)) && in_sel) begin
            is_warn = 1'b0;
        end
    end

`ifdef LEFTRIGHT_DEDUP_EN
    logic          key_vld;
    logic [3:0]    key_op;
    logic [LW-1:0] key_line;

    assign dup = key_vld && (key_op == in_op) && (key_line == in_line);

    // Remember the last queued key; forgotten at end of module.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_vld  <= 1'b0;
            key_op   <= '0;
            key_line <= '0;
        end else if (state_q == S_DONE) begin
            key_vld  <= 1'b0;
            key_op   <= '0;
            key_line <= '0;
        end else if (push) begin
            key_vld  <= 1'b1;
            key_op   <= in_op;
            key_line <= in_line;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign warn_evt = accept && is_warn && !dup;
    assign pop      = out_valid && out_ready;
    // A full queue still takes a record if the head leaves on the same edge.
    assign push     = warn_evt && (!full || pop);
    assign drop     = warn_evt && full && !pop;

    assign out_valid = !empty;
    assign out_op    = empty ? '0 : op_mem[rd_ptr[AW-1:0]];
    assign out_line  = empty ? '0 : line_mem[rd_ptr[AW-1:0]];
    assign dbg_state = state_q;

    // Record storage; contents are don't-care until written, reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr[AW-1:0]]   <= in_op;
            line_mem[wr_ptr[AW-1:0]] <= in_line;
        end
    end

    // Queue pointers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Saturating per-module counters, cleared on the edge leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warn_cnt <= '0;
            drop_cnt <= '0;
        end else if (state_q == S_DONE) begin
            warn_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && (warn_cnt != '1)) warn_cnt <= warn_cnt + 1'b1;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Next state and per-state outputs; DRAIN ends on the cycle the queue empties.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        mod_done = 1'b0;
        case (state_q)
            S_RUN: begin
                in_ready = 1'b1;
                if (accept && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty || ((fill == (AW+1)'(1)) && pop)) state_d = S_DONE;
            end
            S_DONE: begin
                mod_done = 1'b1;
                state_d  = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_leftright_warn_filter.sv
// tb_leftright_warn_filter
//   Directed scenarios plus random traffic against a queue-based reference
//   model; every cycle the DUT outputs are compared with the model.
module tb_leftright_warn_filter;

    localparam int LW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic          in_same;
    logic          in_one;
    logic          in_sel;
    logic          in_ignore;
    logic [LW-1:0] in_line;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_op;
    logic [LW-1:0] out_line;
    logic [CW-1:0] warn_cnt;
    logic [CW-1:0] drop_cnt;
    logic          mod_done;
    logic [1:0]    dbg_state;

    leftright_warn_filter #(.LW(LW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_same(in_same), .in_one(in_one), .in_sel(in_sel),
        .in_ignore(in_ignore), .in_line(in_line), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_line(out_line),
        .warn_cnt(warn_cnt), .drop_cnt(drop_cnt),
        .mod_done(mod_done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [LW+3:0] exp_q[$];
    int            m_phase;   // 0 accepting, 1 draining, 2 end-of-module cycle
    int            m_wc, m_dc;
    bit            m_acc, m_pop, m_w;
    logic [LW+3:0] m_rec;
`ifdef LEFTRIGHT_DEDUP_EN
    bit            m_kv;
    logic [LW+3:0] m_key;
`endif

    function automatic bit rule_warn(input logic [3:0] op, input bit same, input bit one,
                                     input bit sel, input bit ign);
        if (!same || ign) return 1'b0;
        case (op)
            4'd9:         return 1'b0;      // MUL
            4'd5, 4'd6:   return !one;      // SHL, ASHL
            4'd10, 4'd11: return !sel;      // ADD, SUB
            4'd14, 4'd15: return 1'b0;      // reserved
            default:      return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_phase = 0;
            m_wc    = 0;
            m_dc    = 0;
`ifdef LEFTRIGHT_DEDUP_EN
            m_kv    = 1'b0;
            m_key   = '0;
`endif
        end else begin
            m_acc = in_valid && (m_phase == 0);
            m_pop = (exp_q.size() > 0) && out_ready;
            m_w   = m_acc && rule_warn(in_op, in_same, in_one, in_sel, in_ignore);
            m_rec = {in_op, in_line};
`ifdef LEFTRIGHT_DEDUP_EN
            if (m_w && m_kv && (m_key == m_rec)) m_w = 1'b0;
`endif
            if (m_pop) void'(exp_q.pop_front());
            if (m_w) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(m_rec);
                    if (m_wc < CMAX) m_wc++;
`ifdef LEFTRIGHT_DEDUP_EN
                    m_kv  = 1'b1;
                    m_key = m_rec;
`endif
                end else if (m_dc < CMAX) begin
                    m_dc++;
                end
            end
            case (m_phase)
                0: if (m_acc && in_last) m_phase = 1;
                1: if (exp_q.size() == 0) m_phase = 2;
                default: begin
                    m_phase = 0;
                    m_wc    = 0;
                    m_dc    = 0;
`ifdef LEFTRIGHT_DEDUP_EN
                    m_kv    = 1'b0;
`endif
                end
            endcase
        end
    end

    // ---------------- compare process and output capture ----------------
    logic [LW-1:0] got_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("out_op",    32'(out_op),    (exp_q.size() > 0) ? 32'(exp_q[0][LW+3:LW]) : 32'd0);
            chk("out_line",  32'(out_line),  (exp_q.size() > 0) ? 32'(exp_q[0][LW-1:0])  : 32'd0);
            chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
            chk("mod_done",  32'(mod_done),  32'(m_phase == 2));
            chk("warn_cnt",  32'(warn_cnt),  32'(m_wc));
            chk("drop_cnt",  32'(drop_cnt),  32'(m_dc));
            if (out_valid && out_ready) got_q.push_back(out_line);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] op, input bit same, input bit one, input bit sel,
                        input bit ign, input int line, input bit last);
        in_valid  = 1'b1;
        in_op     = op;
        in_same   = same;
        in_one    = one;
        in_sel    = sel;
        in_ignore = ign;
        in_line   = LW'(line);
        in_last   = last;
        @(posedge clk); #2;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_same   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic end_module();
        int t;
        out_ready = 1'b1;
        send(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        t = 0;
        while (!mod_done && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("mod_done_seen", 32'(mod_done), 32'd1);
        @(posedge clk); #2;
    endtask

    // ---------------- stimulus ----------------
    int pop3_cyc, done_cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_same   = 1'b0;
        in_one    = 1'b0;
        in_sel    = 1'b0;
        in_ignore = 1'b0;
        in_line   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_warn_cnt",  32'(warn_cnt),  32'd0);
        chk("reset_drop_cnt",  32'(drop_cnt),  32'd0);
        chk("reset_mod_done",  32'(mod_done),  32'd0);
        chk("reset_state",     32'(dbg_state), 32'd0);
        @(posedge clk); #2;

        // Rule table: only AND, SHR-of-one and SUB-outside-select survive.
        out_ready = 1'b1;
        got_q.delete();
        send(4'd0,  1, 0, 0, 0, 1, 0);  // AND same
        send(4'd9,  1, 0, 0, 0, 2, 0);  // MUL same
        send(4'd5,  1, 1, 0, 0, 3, 0);  // SHL one
        send(4'd7,  1, 1, 0, 0, 4, 0);  // SHR one
        send(4'd10, 1, 0, 1, 0, 5, 0);  // ADD in select
        send(4'd11, 1, 0, 0, 0, 6, 0);  // SUB outside select
        send(4'd12, 1, 0, 0, 1, 7, 0);  // QMARK ignored
        idle(3);
        chk("rule_warn_cnt", 32'(warn_cnt), 32'd3);
        chk("rule_nrec", 32'(got_q.size()), 32'd3);
        chk("rule_rec0", 32'(got_q[0]), 32'd1);
        chk("rule_rec1", 32'(got_q[1]), 32'd4);
        chk("rule_rec2", 32'(got_q[2]), 32'd6);
        end_module();

        // Overflow, then a push that coincides with a pop on a full queue.
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 10; i++) send(4'd0, 1, 0, 0, 0, i, 0);
        @(negedge clk); #1;
        chk("ovf_warn_cnt", 32'(warn_cnt), 32'd8);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        @(posedge clk); #2;
        out_ready = 1'b1;
        send(4'd0, 1, 0, 0, 0, 11, 0);
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk("fullpp_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("fullpp_warn_cnt", 32'(warn_cnt), 32'd9);
        chk("fullpp_head", 32'(out_line), 32'd2);
        @(posedge clk); #2;
        out_ready = 1'b1;
        idle(12);
        chk("ovf_nrec", 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 8; i++) chk("ovf_order", 32'(got_q[i]), 32'(i + 1));
        chk("fullpp_last", 32'(got_q[8]), 32'd11);
        end_module();

        // End of module with two records queued.
        out_ready = 1'b0;
        got_q.delete();
        send(4'd1, 1, 0, 0, 0, 21, 0);
        send(4'd1, 1, 0, 0, 0, 22, 0);
        out_ready = 1'b1;
        send(4'd0, 1, 0, 0, 0, 23, 1);
        pop3_cyc = -100;
        done_cyc = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk); #1;
            if (mod_done) begin
                done_cyc = cyc;
                break;
            end
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            if (got_q.size() == 3 && pop3_cyc < 0) pop3_cyc = cyc;
        end
        chk("eom_latency", 32'(done_cyc - pop3_cyc), 32'd1);
        chk("eom_warn_cnt", 32'(warn_cnt), 32'd3);
        chk("eom_nrec", 32'(got_q.size()), 32'd3);
        @(negedge clk); #1;
        chk("post_eom_warn_cnt", 32'(warn_cnt), 32'd0);
        chk("post_eom_in_ready", 32'(in_ready), 32'd1);
        chk("post_eom_mod_done", 32'(mod_done), 32'd0);
        @(posedge clk); #2;

        // Repeated key at the same line.
        out_ready = 1'b1;
        got_q.delete();
        send(4'd0, 1, 0, 0, 0, 42, 0);
        send(4'd0, 1, 0, 0, 0, 42, 0);
        send(4'd1, 1, 0, 0, 0, 42, 0);
        idle(4);
`ifdef LEFTRIGHT_DEDUP_EN
        chk("dedup_nrec", 32'(got_q.size()), 32'd2);
`else
        chk("dedup_nrec", 32'(got_q.size()), 32'd3);
`endif
        end_module();

        // Counter saturation.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(4'd10, 1, 0, 0, 0, 100 + i, 0);
        idle(2);
        chk("sat_warn_cnt", 32'(warn_cnt), 32'(CMAX));
        end_module();

        // Reset mid-stream with three records queued.
        out_ready = 1'b0;
        got_q.delete();
        send(4'd2, 1, 0, 0, 0, 201, 0);
        send(4'd3, 1, 0, 0, 0, 202, 0);
        send(4'd4, 1, 0, 0, 0, 203, 0);
        @(negedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_warn_cnt",  32'(warn_cnt),  32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(5);
        chk("post_rst_nrec", 32'(got_q.size()), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_same   = ($urandom_range(0, 7) != 0);
            in_one    = 1'($urandom_range(0, 1));
            in_sel    = 1'($urandom_range(0, 1));
            in_ignore = ($urandom_range(0, 9) == 0);
            in_line   = LW'($urandom_range(0, 7));
            in_last   = ($urandom_range(0, 39) == 0);
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 4) == 0);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
